mult_div_unit: RTL

Iterative multiply/divide unit for the MIPS core, sitting directly downstream of the register file. It consumes the two register read ports (rs, rt) for MULT/MULTU/DIV/DIVU, computes over 32 iterations into the architectural HI/LO pair, and feeds HI/LO back toward the register-file write port for MFHI/MFLO. A busy flag stalls the core while an operation is in flight.

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu_div_step.sv | 32 +++
 rtl/mult_div_unit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared op encodings, FSM state type and iteration count for
//               the iterative multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

  localparam int ITER = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mdu_div_step.sv
`default_nettype none
// ============================================================================
// Module      : mdu_div_step
// Description : One restoring-division iteration. Shifts the next dividend
//               bit into the partial remainder, trial-subtracts the divisor
//               and either keeps the difference (quotient bit 1) or restores.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   w_trial;
  logic [WIDTH+1:0] w_diff;

  // 33-bit partial remainder; the extra MSB of the difference is the borrow.
  // Since rem_in < divisor, the kept result always fits back in WIDTH bits.
  always_comb begin
    w_trial = {rem_in, dividend_bit};
    w_diff  = {1'b0, w_trial} - {2'b00, divisor};
    q_bit   = ~w_diff[WIDTH+1];
    rem_out = q_bit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
//               IDLE -> CALC (WIDTH cycles) -> FIX (sign fix, write, done).
//               Build option MDU_DIV_EN compiles in the divide datapath;
//               without it, divide ops skip straight to FIX and leave HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = ITER
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             neg_res_q, neg_res_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  // Operand decode and magnitude conversion at the start edge.
  logic             w_is_signed, w_is_div, w_a_neg, w_b_neg, w_q_is_mul;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;

  assign w_is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign w_is_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign w_a_neg     = w_is_signed & operand_a[WIDTH-1];
  assign w_b_neg     = w_is_signed & operand_b[WIDTH-1];
  assign w_a_mag     = w_a_neg ? -operand_a : operand_a;
  assign w_b_mag     = w_b_neg ? -operand_b : operand_b;
  assign w_q_is_mul  = (op_q == OP_MULT) || (op_q == OP_MULTU);

  // Shift-add multiply: acc = {partial product, remaining multiplier bits}.
  // opnd_q holds the multiplicand; the carry lands in the shifted-in MSB.
  logic [WIDTH:0]  w_mul_sum;
  logic [W2-1:0]   w_mul_acc;
  logic [W2-1:0]   w_prod;

  assign w_mul_sum = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, {WIDTH{acc_q[0]}} & opnd_q};
  assign w_mul_acc = {w_mul_sum, acc_q[WIDTH-1:1]};
  assign w_prod    = neg_res_q ? -acc_q : acc_q;

`ifdef MDU_DIV_EN
  // Restoring divide: acc = {partial remainder, dividend bits / quotient}.
  // opnd_q holds the divisor. Divide by zero keeps the natural all-ones
  // quotient unsigned; the remainder sign fix then reproduces operand_a.
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] w_div_rem;
  logic             w_div_qbit;
  logic [W2-1:0]    w_div_acc;
  logic             w_div_zero;
  logic [WIDTH-1:0] w_quot_fix, w_rem_fix;

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in       (acc_q[W2-1:WIDTH]),
    .dividend_bit (acc_q[WIDTH-1]),
    .divisor      (opnd_q),
    .rem_out      (w_div_rem),
    .q_bit        (w_div_qbit)
  );

  assign w_div_acc  = {w_div_rem, acc_q[WIDTH-2:0], w_div_qbit};
  assign w_div_zero = (opnd_q == '0);
  assign w_quot_fix = (neg_res_q && !w_div_zero) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign w_rem_fix  = neg_rem_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
`endif

  // Next-state, datapath and HI/LO update logic.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
`ifdef MDU_DIV_EN
    neg_rem_d = neg_rem_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d      = op;
          neg_res_d = w_a_neg ^ w_b_neg;
          opnd_d    = w_is_div ? w_b_mag : w_a_mag;
          acc_d     = {{WIDTH{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
          count_d   = '0;
          state_d   = CALC;
`ifdef MDU_DIV_EN
          neg_rem_d = w_a_neg;
`else
          if (w_is_div) state_d = FIX;
`endif
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      CALC: begin
`ifdef MDU_DIV_EN
        acc_d = w_q_is_mul ? w_mul_acc : w_div_acc;
`else
        acc_d = w_mul_acc;
`endif
        count_d = count_q + 1'b1;
        if (count_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (w_q_is_mul) begin
          hi_d = w_prod[W2-1:WIDTH];
          lo_d = w_prod[WIDTH-1:0];
        end
`ifdef MDU_DIV_EN
        else begin
          hi_d = w_rem_fix;
          lo_d = w_quot_fix;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
`ifdef MDU_DIV_EN
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
`ifdef MDU_DIV_EN
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire
